// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall control slice
package hazard_pkg;

    // Default register-index width for the core.
    localparam int REG_BITS = 5;

    // x0 is hard-wired to zero, so writes to it never create a dependency.
    localparam logic [REG_BITS-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - load-use comparator between the execute destination and decode sources
//
// Purpose: raises hit when the load in execute writes a register that the
// instruction in decode reads. Purely combinational.
// Ports:
//   rs1_decode, rs2_decode             source indices of the decode instruction
//   rs1_used_decode, rs2_used_decode   the decode instruction actually reads that source
//   rd_execute                         destination of the execute instruction
//   memRead_execute, regWrite_execute  execute instruction is a register-writing load
//   hit                                load-use hazard present this cycle
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_BITS = hazard_pkg::REG_BITS
) (
    input  logic [REG_BITS-1:0] rs1_decode,
    input  logic [REG_BITS-1:0] rs2_decode,
    input  logic                rs1_used_decode,
    input  logic                rs2_used_decode,
    input  logic [REG_BITS-1:0] rd_execute,
    input  logic                memRead_execute,
    input  logic                regWrite_execute,
    output logic                hit
);

    logic writes_real_reg;
    logic rs1_match;
    logic rs2_match;

    assign writes_real_reg = memRead_execute && regWrite_execute
                             && (rd_execute != REG_BITS'(ZERO_REG));
    assign rs1_match       = rs1_used_decode && (rs1_decode == rd_execute);
    assign rs2_match       = rs2_used_decode && (rs2_decode == rd_execute);
    assign hit             = writes_real_reg && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush/freeze generator for the in-order pipeline
//
// Purpose: decides per cycle whether fetch and the fetch->decode register hold
// or squash, whether decode->execute loads a bubble, and whether the whole pipe
// freezes for a data-memory wait. Priority is memory wait > redirect > load-use.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
// Ports:
//   clock, reset          core clock, asynchronous active-high reset
//   rs1/rs2_decode (+used) decode source operands
//   rd_execute, memRead_execute, regWrite_execute  execute-stage destination info
//   redirect_execute      taken branch / jump resolved in execute
//   mem_req_memory, mem_ready  data-memory handshake of the memory stage
//   stall_fetch, stall_decode, flush_decode, bubble_execute, freeze  pipeline controls
//   stall_cycles_count, flush_cycles_count  (HAZARD_PERF_CNT_EN only) saturating counters
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS          = hazard_pkg::REG_BITS,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] rs1_decode,
    input  logic [REG_BITS-1:0] rs2_decode,
    input  logic                rs1_used_decode,
    input  logic                rs2_used_decode,
    input  logic [REG_BITS-1:0] rd_execute,
    input  logic                memRead_execute,
    input  logic                regWrite_execute,
    input  logic                redirect_execute,
    input  logic                mem_req_memory,
    input  logic                mem_ready,
    output logic                stall_fetch,
    output logic                stall_decode,
    output logic                flush_decode,
    output logic                bubble_execute,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]         stall_cycles_count,
    output logic [31:0]         flush_cycles_count,
`endif
    output logic                freeze
);

    // Counter reload values: the first stall/flush cycle is issued from RUN,
    // so the extra state only covers the remaining cycles.
    localparam logic [1:0] LOAD_RELOAD  = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    hazard_state_e state, state_next;
    logic [1:0]    cnt, cnt_next;
    logic          hit;
    logic          mem_wait;

    hazard_match #(
        .REG_BITS(REG_BITS)
    ) u_match (
        .rs1_decode      (rs1_decode),
        .rs2_decode      (rs2_decode),
        .rs1_used_decode (rs1_used_decode),
        .rs2_used_decode (rs2_used_decode),
        .rd_execute      (rd_execute),
        .memRead_execute (memRead_execute),
        .regWrite_execute(regWrite_execute),
        .hit             (hit)
    );

    assign mem_wait = mem_req_memory && !mem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        flush_decode   = 1'b0;
        bubble_execute = 1'b0;
        freeze         = 1'b0;

        if (reset) begin
            // Outputs stay low for the whole reset window.
        end else if (mem_wait) begin
            // Held stages re-present redirect/hit once the wait ends, so
            // nothing else is acted on and the FSM keeps its place.
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            freeze       = 1'b1;
        end else if (redirect_execute) begin
            // Same action from every state: squash the wrong-path work and
            // (re)start the flush window.
            flush_decode   = 1'b1;
            bubble_execute = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_RELOAD;
            end else begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (hit) begin
                        stall_fetch    = 1'b1;
                        stall_decode   = 1'b1;
                        bubble_execute = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_next = LOAD_STALL;
                            cnt_next   = LOAD_RELOAD;
                        end
                    end
                end
                LOAD_STALL: begin
                    stall_fetch    = 1'b1;
                    stall_decode   = 1'b1;
                    bubble_execute = 1'b1;
                    cnt_next       = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    flush_decode   = 1'b1;
                    bubble_execute = 1'b1;
                    cnt_next       = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Wait cycles drive neither bubble nor flush, so the counters hold then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_count <= 32'd0;
            flush_cycles_count <= 32'd0;
        end else begin
            if (bubble_execute && !flush_decode && (stall_cycles_count != 32'hFFFF_FFFF)) begin
                stall_cycles_count <= stall_cycles_count + 32'd1;
            end
            if (flush_decode && (flush_cycles_count != 32'hFFFF_FFFF)) begin
                flush_cycles_count <= flush_cycles_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    // Expected output vectors, ordered {stall_fetch, stall_decode, flush_decode, bubble_execute, freeze}.
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11010;
    localparam logic [4:0] O_FLUSH = 5'b00110;
    localparam logic [4:0] O_WAIT  = 5'b11001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, reset_b;
    logic [4:0] rs1_decode, rs2_decode, rd_execute;
    logic       rs1_used_decode, rs2_used_decode;
    logic       memRead_execute, regWrite_execute, redirect_execute;
    logic       mem_req_memory, mem_ready;

    logic sf_a, sd_a, fd_a, be_a, fz_a;
    logic sf_b, sd_b, fd_b, be_b, fz_b;
    logic [4:0] outs_a, outs_b;
    assign outs_a = {sf_a, sd_a, fd_a, be_a, fz_a};
    assign outs_b = {sf_b, sd_b, fd_b, be_b, fz_b};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    string       tag_q[$];
    logic [31:0] model_stall = 32'd0;
    logic [31:0] model_flush = 32'd0;

    // dut_a: default parameters (1 load bubble, 2 flush cycles)
    hazard_stall_unit dut_a (
        .clock            (clock),
        .reset            (reset_a),
        .rs1_decode       (rs1_decode),
        .rs2_decode       (rs2_decode),
        .rs1_used_decode  (rs1_used_decode),
        .rs2_used_decode  (rs2_used_decode),
        .rd_execute       (rd_execute),
        .memRead_execute  (memRead_execute),
        .regWrite_execute (regWrite_execute),
        .redirect_execute (redirect_execute),
        .mem_req_memory   (mem_req_memory),
        .mem_ready        (mem_ready),
        .stall_fetch      (sf_a),
        .stall_decode     (sd_a),
        .flush_decode     (fd_a),
        .bubble_execute   (be_a),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles_count(stall_cnt_a),
        .flush_cycles_count(flush_cnt_a),
`endif
        .freeze           (fz_a)
    );

    // dut_b: two load bubbles, for multi-cycle LOAD_STALL behaviour
    hazard_stall_unit #(
        .LOAD_STALL_CYCLES(2),
        .FLUSH_CYCLES     (2)
    ) dut_b (
        .clock            (clock),
        .reset            (reset_b),
        .rs1_decode       (rs1_decode),
        .rs2_decode       (rs2_decode),
        .rs1_used_decode  (rs1_used_decode),
        .rs2_used_decode  (rs2_used_decode),
        .rd_execute       (rd_execute),
        .memRead_execute  (memRead_execute),
        .regWrite_execute (regWrite_execute),
        .redirect_execute (redirect_execute),
        .mem_req_memory   (mem_req_memory),
        .mem_ready        (mem_ready),
        .stall_fetch      (sf_b),
        .stall_decode     (sd_b),
        .flush_decode     (fd_b),
        .bubble_execute   (be_b),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles_count(stall_cnt_b),
        .flush_cycles_count(flush_cnt_b),
`endif
        .freeze           (fz_b)
    );

    task automatic idle();
        rs1_decode       = 5'd0;
        rs2_decode       = 5'd0;
        rd_execute       = 5'd0;
        rs1_used_decode  = 1'b0;
        rs2_used_decode  = 1'b0;
        memRead_execute  = 1'b0;
        regWrite_execute = 1'b0;
        redirect_execute = 1'b0;
        mem_req_memory   = 1'b0;
        mem_ready        = 1'b0;
    endtask

    // Load x5 in execute, decode reads x5 on rs1.
    task automatic load_use();
        memRead_execute  = 1'b1;
        regWrite_execute = 1'b1;
        rd_execute       = 5'd5;
        rs1_decode       = 5'd5;
        rs1_used_decode  = 1'b1;
        rs2_decode       = 5'd1;
        rs2_used_decode  = 1'b1;
    endtask

    task automatic check_step();
        logic [9:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert ({outs_a, outs_b} === e)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, {outs_a, outs_b}, e);
        end
    endtask

    // Inputs are already applied; outputs are sampled mid-cycle, then the
    // clock advances to just past the next rising edge.
    task automatic step(input string t, input logic [4:0] ea, input logic [4:0] eb);
        exp_q.push_back({ea, eb});
        tag_q.push_back(t);
        #2;
        check_step();
        if (!reset_a) begin
            if (ea[1] && !ea[2]) model_stall++;
            if (ea[2]) model_flush++;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        idle();
        step("reset", O_NONE, O_NONE);
        reset_a = 1'b0;
        step("run_idle", O_NONE, O_NONE);

        // T1: single load-use bubble
        load_use();
        step("t1_hit", O_STALL, O_NONE);
        idle();
        step("t1_release", O_NONE, O_NONE);

        // T2: x0 destination, unused rs2, load not writing back
        memRead_execute = 1'b1; regWrite_execute = 1'b1; rd_execute = 5'd0;
        rs1_decode = 5'd0; rs1_used_decode = 1'b1;
        step("t2_x0", O_NONE, O_NONE);
        rd_execute = 5'd7; rs1_decode = 5'd3; rs2_decode = 5'd7; rs2_used_decode = 1'b0;
        step("t2_rs2_unused", O_NONE, O_NONE);
        rs2_used_decode = 1'b1;
        step("t2_rs2_hit", O_STALL, O_NONE);
        regWrite_execute = 1'b0;
        step("t2_no_regwrite", O_NONE, O_NONE);
        idle();

        // T3: redirect gives exactly two flush cycles
        redirect_execute = 1'b1;
        step("t3_flush0", O_FLUSH, O_NONE);
        redirect_execute = 1'b0;
        step("t3_flush1", O_FLUSH, O_NONE);
        step("t3_done", O_NONE, O_NONE);

        // T4a: redirect beats load-use; hit ignored inside FLUSH
        load_use();
        redirect_execute = 1'b1;
        step("t4_hit_redirect", O_FLUSH, O_NONE);
        redirect_execute = 1'b0;
        step("t4_hit_in_flush", O_FLUSH, O_NONE);
        idle();
        step("t4_done", O_NONE, O_NONE);

        // T5: memory wait freezes FLUSH with one cycle left
        redirect_execute = 1'b1;
        step("t5_flush0", O_FLUSH, O_NONE);
        redirect_execute = 1'b0;
        mem_req_memory = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("t5_wait%0d", i), O_WAIT, O_NONE);
        end
        mem_ready = 1'b1;
        step("t5_flush_resume", O_FLUSH, O_NONE);
        mem_req_memory = 1'b0;
        step("t5_done", O_NONE, O_NONE);

        // Wait beats load-use, then the hazard is serviced
        load_use();
        mem_req_memory = 1'b1;
        mem_ready = 1'b0;
        step("wait_over_hit", O_WAIT, O_NONE);
        mem_ready = 1'b1;
        step("hit_after_wait", O_STALL, O_NONE);
        idle();
        step("hit_wait_done", O_NONE, O_NONE);

        // Wait beats redirect, then the full flush follows
        redirect_execute = 1'b1;
        mem_req_memory = 1'b1;
        mem_ready = 1'b0;
        step("wait_over_redirect", O_WAIT, O_NONE);
        mem_ready = 1'b1;
        step("redirect_after_wait", O_FLUSH, O_NONE);
        idle();
        step("redirect_after_wait1", O_FLUSH, O_NONE);
        step("redirect_wait_done", O_NONE, O_NONE);

`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt_a === model_stall)
        else begin
            errors++;
            $error("FAIL perf_stall observed=%0d expected=%0d", stall_cnt_a, model_stall);
        end
        checks++;
        assert (flush_cnt_a === model_flush)
        else begin
            errors++;
            $error("FAIL perf_flush observed=%0d expected=%0d", flush_cnt_a, model_flush);
        end
`endif

        // Switch to dut_b
        reset_a = 1'b1;
        reset_b = 1'b0;
        step("b_idle", O_NONE, O_NONE);

        // Two-cycle load stall
        load_use();
        step("b_hit0", O_NONE, O_STALL);
        step("b_hit1", O_NONE, O_STALL);
        idle();
        step("b_release", O_NONE, O_NONE);

        // T4b: redirect in the second load-stall cycle enters FLUSH
        load_use();
        step("b_t4_stall", O_NONE, O_STALL);
        redirect_execute = 1'b1;
        step("b_t4_redirect", O_NONE, O_FLUSH);
        idle();
        step("b_t4_flush1", O_NONE, O_FLUSH);
        step("b_t4_done", O_NONE, O_NONE);

        // T6: reset inside LOAD_STALL
        load_use();
        step("b_t6_stall", O_NONE, O_STALL);
        reset_b = 1'b1;
        step("b_t6_reset_held", O_NONE, O_NONE);
        reset_b = 1'b0;
        step("b_t6_restall", O_NONE, O_STALL);
        // Short pulse between edges: only an asynchronous reset clears LOAD_STALL.
        reset_b = 1'b1;
        #1;
        reset_b = 1'b0;
        idle();
        step("b_t6_async_reset", O_NONE, O_NONE);
        step("b_t6_run", O_NONE, O_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
